// File: rtl/aes_bram_port_pkg.sv
// Shared definitions for the AES BRAM responder: state encoding, word size,
// and the default BRAM address width used by the top level.
package aes_bram_port_pkg;

  localparam int unsigned WORD_BYTES      = 4;
  localparam int unsigned BRAM_ADDR_W_DEF = 12;
  localparam int unsigned COUNT_W         = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_WR_ISSUE = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/aes_sat_counter.sv
// Increment-enable counter that sticks at all-ones instead of wrapping.
module aes_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/aes_bram_port.sv
// Memory-side responder for the AES block FSM: turns level-held read/write
// requests into single BRAM port accesses with a 4-phase completion handshake.
module aes_bram_port
  import aes_bram_port_pkg::*;
#(
  parameter int unsigned BRAM_ADDR_W = BRAM_ADDR_W_DEF,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic                   aes_clk,
  input  logic                   aes_rst_n,
  input  logic                   aes_start_read,
  input  logic                   aes_start_write,
  input  logic [31:0]            aes_bram_addr,
  input  logic [31:0]            aes_bram_write_data,
  output logic [31:0]            aes_bram_read_data,
  output logic                   bram_complete,
  output logic                   bram_err,
  output logic                   busy,
  output logic                   bram_en,
  output logic [3:0]             bram_we,
  output logic [BRAM_ADDR_W-1:0] bram_addr,
  output logic [31:0]            bram_din,
  input  logic [31:0]            bram_dout,
  output logic [31:0]            rd_count,
  output logic [31:0]            wr_count
);

  localparam int unsigned LAT_W = 3;
  localparam logic [32:0] LIMIT_BYTES = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic [31:0]      offset_c;
  logic             reject_c;
  logic             rd_done_c;
  logic             wr_done_c;

  // Underflow below BASE_ADDR wraps to a huge offset and fails the range check.
  assign offset_c  = aes_bram_addr - BASE_ADDR;
  assign reject_c  = (aes_bram_addr[1:0] != 2'b00) || ({1'b0, offset_c} >= LIMIT_BYTES);
  assign rd_done_c = (state == ST_RD_WAIT) && (lat_cnt == '0);
  assign wr_done_c = (state == ST_WR_ISSUE);

  always_ff @(posedge aes_clk or negedge aes_rst_n) begin
    if (!aes_rst_n) begin
      state              <= ST_IDLE;
      lat_cnt            <= '0;
      aes_bram_read_data <= '0;
      bram_complete      <= 1'b0;
      bram_err           <= 1'b0;
      busy               <= 1'b0;
      bram_en            <= 1'b0;
      bram_we            <= 4'h0;
      bram_addr          <= '0;
      bram_din           <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (aes_start_read || aes_start_write) begin
            busy <= 1'b1;
            if (reject_c) begin
              bram_complete <= 1'b1;
              bram_err      <= 1'b1;
              state         <= ST_DONE;
            end else begin
              bram_en   <= 1'b1;
              bram_addr <= offset_c[BRAM_ADDR_W+1:2];
              // Write wins when both requests arrive together.
              if (aes_start_write) begin
                bram_we  <= 4'hF;
                bram_din <= aes_bram_write_data;
                state    <= ST_WR_ISSUE;
              end else begin
                bram_we <= 4'h0;
                lat_cnt <= LAT_W'(RD_LATENCY);
                state   <= ST_RD_WAIT;
              end
            end
          end
        end

        ST_RD_WAIT: begin
          bram_en <= 1'b0;
          if (lat_cnt == '0) begin
            aes_bram_read_data <= bram_dout;
            bram_complete      <= 1'b1;
            state              <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end

        ST_WR_ISSUE: begin
          bram_en       <= 1'b0;
          bram_we       <= 4'h0;
          bram_complete <= 1'b1;
          state         <= ST_DONE;
        end

        ST_DONE: begin
          // A request still held here is the one just served; never retrigger.
          if (!aes_start_read && !aes_start_write) begin
            bram_complete <= 1'b0;
            bram_err      <= 1'b0;
            busy          <= 1'b0;
            state         <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  aes_sat_counter #(.W(COUNT_W)) u_rd_count (
    .clk   (aes_clk),
    .rst_n (aes_rst_n),
    .inc   (rd_done_c),
    .count (rd_count)
  );

  aes_sat_counter #(.W(COUNT_W)) u_wr_count (
    .clk   (aes_clk),
    .rst_n (aes_rst_n),
    .inc   (wr_done_c),
    .count (wr_count)
  );

endmodule

// File: tb/tb_aes_bram_port.sv
// Self-checking bench for aes_bram_port with a behavioural 2-cycle BRAM and a
// read-data scoreboard.
module tb_aes_bram_port;

  localparam int unsigned AW = 12;

  logic        clk;
  logic        rst_n;
  logic        start_read, start_write;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] read_data;
  logic        complete, err, busy;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0] bram_din, bram_dout;
  logic [31:0] rd_count, wr_count;

  logic        start_read_b, start_write_b;
  logic [31:0] addr_b, wdata_b;
  logic [31:0] read_data_b;
  logic        complete_b, err_b, busy_b;
  logic        bram_en_b;
  logic [3:0]  bram_we_b;
  logic [AW-1:0] bram_addr_b;
  logic [31:0] bram_din_b;
  logic [31:0] bram_dout_b;
  logic [31:0] rd_count_b, wr_count_b;

  int n_chk = 0;
  int n_pass = 0;
  int en_cnt = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic [31:0] last_rd = 32'h0;
  logic [31:0] sb[$];
  logic [31:0] model [int];

  aes_bram_port #(.BRAM_ADDR_W(AW), .DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .RD_LATENCY(2)) dut (
    .aes_clk(clk), .aes_rst_n(rst_n),
    .aes_start_read(start_read), .aes_start_write(start_write),
    .aes_bram_addr(addr_i), .aes_bram_write_data(wdata_i),
    .aes_bram_read_data(read_data), .bram_complete(complete), .bram_err(err), .busy(busy),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout), .rd_count(rd_count), .wr_count(wr_count)
  );

  aes_bram_port #(.BRAM_ADDR_W(AW), .DEPTH_WORDS(4096), .BASE_ADDR(32'h1000), .RD_LATENCY(2)) dut_b (
    .aes_clk(clk), .aes_rst_n(rst_n),
    .aes_start_read(start_read_b), .aes_start_write(start_write_b),
    .aes_bram_addr(addr_b), .aes_bram_write_data(wdata_b),
    .aes_bram_read_data(read_data_b), .bram_complete(complete_b), .bram_err(err_b), .busy(busy_b),
    .bram_en(bram_en_b), .bram_we(bram_we_b), .bram_addr(bram_addr_b), .bram_din(bram_din_b),
    .bram_dout(bram_dout_b), .rd_count(rd_count_b), .wr_count(wr_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM with two-cycle read latency: address sampled on the enable edge,
  // data lands one edge later.
  bit [31:0] mem [4096];
  logic [31:0] p1 = 32'h0;
  initial bram_dout = 32'h0;
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we == 4'hF) mem[bram_addr] <= bram_din;
      else p1 <= mem[bram_addr];
    end
    bram_dout <= p1;
  end

  always @(posedge clk) if (bram_en === 1'b1) en_cnt <= en_cnt + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic do_op(input string name, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input int exp_lat, input int hold);
    int k;
    int en0;
    int bad_hold;
    logic [31:0] exp_data;
    en0 = en_cnt;
    @(negedge clk);
    start_read = rd; start_write = wr; addr_i = addr; wdata_i = wdata;
    if (!exp_err) begin
      if (wr) begin
        model[int'(addr >> 2)] = wdata;
        exp_wr++;
      end else begin
        sb.push_back(model.exists(int'(addr >> 2)) ? model[int'(addr >> 2)] : 32'h0);
        exp_rd++;
      end
    end
    @(posedge clk); #1;
    n_chk++;
    if (bram_en !== !exp_err) $display("FAIL %s t0_en: got %b want %b", name, bram_en, !exp_err);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b1) $display("FAIL %s t0_busy: got %b want 1", name, busy);
    else n_pass++;
    if (!exp_err) begin
      n_chk++;
      if (bram_addr !== addr[AW+1:2] || bram_we !== (wr ? 4'hF : 4'h0))
        $display("FAIL %s t0_port: got addr %h we %h want addr %h we %h", name, bram_addr, bram_we,
                 addr[AW+1:2], (wr ? 4'hF : 4'h0));
      else n_pass++;
      if (wr) begin
        n_chk++;
        if (bram_din !== wdata) $display("FAIL %s t0_din: got %h want %h", name, bram_din, wdata);
        else n_pass++;
      end
    end
    k = 0;
    while (complete !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    n_chk++;
    if (k !== exp_lat) $display("FAIL %s latency: got %0d want %0d", name, k, exp_lat);
    else n_pass++;
    n_chk++;
    if (err !== exp_err) $display("FAIL %s err: got %b want %b", name, err, exp_err);
    else n_pass++;
    if (!exp_err && rd && !wr) begin
      exp_data = (sb.size() > 0) ? sb.pop_front() : 32'hX;
      last_rd = exp_data;
    end else begin
      exp_data = last_rd;
    end
    n_chk++;
    if (read_data !== exp_data) $display("FAIL %s read_data: got %h want %h", name, read_data, exp_data);
    else n_pass++;
    n_chk++;
    if (rd_count !== 32'(exp_rd) || wr_count !== 32'(exp_wr))
      $display("FAIL %s counters: got rd %0d wr %0d want rd %0d wr %0d", name, rd_count, wr_count, exp_rd, exp_wr);
    else n_pass++;
    bad_hold = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (complete !== 1'b1) bad_hold++;
    end
    if (hold > 0) begin
      n_chk++;
      if (bad_hold != 0) $display("FAIL %s hold_complete: got %0d low cycles want 0", name, bad_hold);
      else n_pass++;
    end
    @(negedge clk);
    start_read = 1'b0; start_write = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (complete !== 1'b0 || err !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s release: got complete %b err %b busy %b want 0 0 0", name, complete, err, busy);
    else n_pass++;
    n_chk++;
    if (en_cnt - en0 !== (exp_err ? 0 : 1))
      $display("FAIL %s en_cycles: got %0d want %0d", name, en_cnt - en0, (exp_err ? 0 : 1));
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_read = 0; start_write = 0; addr_i = 0; wdata_i = 0;
    start_read_b = 0; start_write_b = 0; addr_b = 0; wdata_b = 0;
    bram_dout_b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({read_data, complete, err, busy, bram_en, bram_we, bram_addr, bram_din, rd_count, wr_count} !== '0)
      $display("FAIL reset_outputs: got nonzero outputs rd %h c %b e %b b %b en %b cnt %0d/%0d want all 0",
               read_data, complete, err, busy, bram_en, rd_count, wr_count);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    do_op("write_cafe", 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, 1, 0);
    do_op("write_dead", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1, 0);
    do_op("write_top", 1'b0, 1'b1, 32'h3FFC, 32'h0BADF00D, 1'b0, 1, 0);
  endtask

  task automatic test_read();
    do_op("read_dead", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 3, 0);
    do_op("read_cafe", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 3, 0);
    do_op("read_top", 1'b1, 1'b0, 32'h3FFC, 32'h0, 1'b0, 3, 0);
  endtask

  task automatic test_errors();
    do_op("misaligned", 1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 0, 0);
    do_op("out_of_range", 1'b0, 1'b1, 32'h4000, 32'h1111_2222, 1'b1, 0, 0);
    @(negedge clk);
    start_read_b = 1'b1; addr_b = 32'h0FFC;
    @(posedge clk); #1;
    n_chk++;
    if (complete_b !== 1'b1 || err_b !== 1'b1 || bram_en_b !== 1'b0)
      $display("FAIL below_base: got complete %b err %b en %b want 1 1 0", complete_b, err_b, bram_en_b);
    else n_pass++;
    @(negedge clk);
    start_read_b = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (complete_b !== 1'b0 || err_b !== 1'b0 || rd_count_b !== 32'h0 || wr_count_b !== 32'h0)
      $display("FAIL below_base_release: got complete %b err %b rd %0d wr %0d want 0 0 0 0",
               complete_b, err_b, rd_count_b, wr_count_b);
    else n_pass++;
  endtask

  task automatic test_both();
    do_op("both_high", 1'b1, 1'b1, 32'h8, 32'h1234_5678, 1'b0, 1, 0);
    do_op("both_readback", 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 3, 0);
  endtask

  task automatic test_hold();
    do_op("hold_read", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 3, 10);
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    start_read = 1'b1; addr_i = 32'h20;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({read_data, complete, err, busy, bram_en, bram_we, bram_addr, bram_din, rd_count, wr_count} !== '0)
      $display("FAIL reset_mid_outputs: got rd %h c %b b %b en %b cnt %0d/%0d want all 0",
               read_data, complete, busy, bram_en, rd_count, wr_count);
    else n_pass++;
    exp_rd = 0; exp_wr = 0; last_rd = 32'h0;
    @(negedge clk);
    start_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (complete !== 1'b0) seen++;
    end
    n_chk++;
    if (seen != 0) $display("FAIL reset_mid_no_complete: got %0d complete cycles want 0", seen);
    else n_pass++;
    do_op("read_after_reset", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 3, 0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_both();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
